// File: rtl/riscv_alu_pkg.sv
// Shared RV32I ALU types: shift opcode encoding, datapath widths, bit-reverse helper.
package riscv_alu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_RSV = 2'b10,
    SHIFT_SRA = 2'b11
  } shift_op_t;

  function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_core_32.sv
// Combinational five-layer 32-bit barrel shifter; left shifts reuse the
// right-shift network by reversing bits on the way in and out.
module shift_core_32 (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  input  logic        dir,
  input  logic        fill,
  output logic [31:0] y
);
  import riscv_alu_pkg::*;

  logic [31:0] layer [0:5];

  assign layer[0] = dir ? bit_reverse(a) : a;

  for (genvar k = 0; k < 5; k++) begin : g_layer
    localparam int unsigned SH = 1 << k;
    assign layer[k+1] = shamt[k] ? {{SH{fill}}, layer[k][31:SH]} : layer[k];
  end

  assign y = dir ? bit_reverse(layer[5]) : layer[5];

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined SLL/SRL/SRA execute unit with valid/ready handshake.
// Define SHIFT_EXEC_SRA_EN to enable arithmetic right shift (op 11).
module shift_exec_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_rd,
  output logic             out_illegal
);
  import riscv_alu_pkg::*;

  logic             s1_valid_q, s1_valid_d;
  shift_op_t        s1_op_q, s1_op_d;
  logic [XLEN-1:0]  s1_a_q, s1_a_d;
  logic [SHAMT_W-1:0] s1_shamt_q, s1_shamt_d;
  logic [TAG_W-1:0] s1_rd_q, s1_rd_d;

  logic             s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]  s2_result_q, s2_result_d;
  logic [TAG_W-1:0] s2_rd_q, s2_rd_d;
  logic             s2_illegal_q, s2_illegal_d;

  logic             s1_adv;
  logic             accept;
  logic             core_dir;
  logic             core_fill;
  logic             op_illegal;
  logic [XLEN-1:0]  core_y;
  logic             unused_b_hi;

  assign unused_b_hi = ^in_b[XLEN-1:SHAMT_W];

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !flush && (!s1_valid_q || s1_adv);
  assign accept   = in_valid && in_ready;

  always_comb begin
    core_dir   = 1'b0;
    core_fill  = 1'b0;
    op_illegal = 1'b0;
    case (s1_op_q)
      SHIFT_SLL: core_dir = 1'b1;
      SHIFT_SRL: core_dir = 1'b0;
`ifdef SHIFT_EXEC_SRA_EN
      SHIFT_SRA: core_fill = s1_a_q[XLEN-1];
`endif
      default:   op_illegal = 1'b1;
    endcase
  end

  shift_core_32 u_core (
    .a     (s1_a_q),
    .shamt (s1_shamt_q),
    .dir   (core_dir),
    .fill  (core_fill),
    .y     (core_y)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_shamt_d = s1_shamt_q;
    s1_rd_d    = s1_rd_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = shift_op_t'(in_op);
      s1_a_d     = in_a;
      s1_shamt_d = in_b[SHAMT_W-1:0];
      s1_rd_d    = in_rd;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 payload only reloads when a valid op moves up, so a stalled result holds.
  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_result_d  = s2_result_q;
    s2_rd_d      = s2_rd_q;
    s2_illegal_d = s2_illegal_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d  = op_illegal ? '0 : core_y;
        s2_rd_d      = s1_rd_q;
        s2_illegal_d = op_illegal;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= SHIFT_SLL;
      s1_a_q       <= '0;
      s1_shamt_q   <= '0;
      s1_rd_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_rd_q      <= '0;
      s2_illegal_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_shamt_q   <= s1_shamt_d;
      s1_rd_q      <= s1_rd_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_rd_q      <= s2_rd_d;
      s2_illegal_q <= s2_illegal_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_rd      = s2_rd_q;
  assign out_illegal = s2_illegal_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed table-driven bench for shift_exec_stage plus hand-written
// backpressure, flush and mid-stream reset sequences.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  shift_exec_stage #(.XLEN(32), .TAG_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_result;
    logic        exp_illegal;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_op    = 2'b00;
    in_a     = '0;
    in_b     = '0;
    in_rd    = '0;
  endtask

  // Issue one op in isolation and check latency and result fields.
  task automatic run_vec(input int i);
    @(negedge clk);
    drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
    chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    idle_in();
    chk($sformatf("v%0d_lat1_valid", i), {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
    chk($sformatf("v%0d_result", i), out_result, vecs[i].exp_result);
    chk($sformatf("v%0d_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].rd});
    chk($sformatf("v%0d_illegal", i), {31'b0, out_illegal}, {31'b0, vecs[i].exp_illegal});
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{2'b00, 32'h00000001, 32'd31,        5'd7,  32'h80000000, 1'b0};
    vecs[1] = '{2'b01, 32'h80000000, 32'hFFFFFFE4,  5'd3,  32'h08000000, 1'b0};
    vecs[2] = '{2'b01, 32'h12345678, 32'd0,         5'd9,  32'h12345678, 1'b0};
`ifdef SHIFT_EXEC_SRA_EN
    vecs[3] = '{2'b11, 32'hF0000000, 32'd4,         5'd12, 32'hFF000000, 1'b0};
    vecs[6] = '{2'b11, 32'h7FFFFFFF, 32'd31,        5'd20, 32'h00000000, 1'b0};
    vecs[8] = '{2'b11, 32'h80000001, 32'd1,         5'd31, 32'hC0000000, 1'b0};
`else
    vecs[3] = '{2'b11, 32'hF0000000, 32'd4,         5'd12, 32'h00000000, 1'b1};
    vecs[6] = '{2'b11, 32'h7FFFFFFF, 32'd31,        5'd20, 32'h00000000, 1'b1};
    vecs[8] = '{2'b11, 32'h80000001, 32'd1,         5'd31, 32'h00000000, 1'b1};
`endif
    vecs[4] = '{2'b10, 32'h12345678, 32'd3,         5'd14, 32'h00000000, 1'b1};
    vecs[5] = '{2'b00, 32'h12345678, 32'hFFFFFFE4,  5'd17, 32'h23456780, 1'b0};
    vecs[7] = '{2'b00, 32'hDEADBEEF, 32'd16,        5'd25, 32'hBEEF0000, 1'b0};
    vecs[9] = '{2'b01, 32'hFFFFFFFF, 32'd31,        5'd1,  32'h00000001, 1'b0};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    idle_in();
    #1;
    chk("rst_out_valid",   {31'b0, out_valid},   32'd0);
    chk("rst_out_result",  out_result,           32'd0);
    chk("rst_out_rd",      {27'b0, out_rd},      32'd0);
    chk("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
    chk("rst_in_ready",    {31'b0, in_ready},    32'd1);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Back-to-back stream with out_ready high: one result per cycle, in order.
    for (int c = 0; c <= NV; c++) begin
      @(negedge clk);
      if (c < NV) begin
        drive(vecs[c].op, vecs[c].a, vecs[c].b, vecs[c].rd);
        chk($sformatf("stream%0d_in_ready", c), {31'b0, in_ready}, 32'd1);
      end else begin
        idle_in();
      end
      @(posedge clk); #1;
      if (c >= 1) begin
        chk($sformatf("stream%0d_valid", c - 1), {31'b0, out_valid}, 32'd1);
        chk($sformatf("stream%0d_result", c - 1), out_result, vecs[c-1].exp_result);
        chk($sformatf("stream%0d_rd", c - 1), {27'b0, out_rd}, {27'b0, vecs[c-1].rd});
      end
    end
    @(posedge clk); #1;
    chk("stream_drained", {31'b0, out_valid}, 32'd0);

    // Backpressure: three ops, out_ready low for 4 cycles.
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'b00, 32'h00000001, 32'd1, 5'd1);
    @(posedge clk); #1;
    @(negedge clk);
    drive(2'b00, 32'h00000001, 32'd2, 5'd2);
    chk("bp_in_ready_op2", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    drive(2'b00, 32'h00000001, 32'd3, 5'd3);
    chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_rd", k), {27'b0, out_rd}, 32'd1);
      chk($sformatf("bp_hold%0d_result", k), out_result, 32'h00000002);
      chk($sformatf("bp_hold%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_rise", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    idle_in();
    chk("bp_out2_rd", {27'b0, out_rd}, 32'd2);
    chk("bp_out2_result", out_result, 32'h00000004);
    @(posedge clk); #1;
    chk("bp_out3_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_out3_rd", {27'b0, out_rd}, 32'd3);
    chk("bp_out3_result", out_result, 32'h00000008);
    @(posedge clk); #1;
    chk("bp_drained", {31'b0, out_valid}, 32'd0);

    // Flush with both stages occupied and a new request presented.
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'b01, 32'h000000F0, 32'd4, 5'd4);
    @(posedge clk); #1;
    @(negedge clk);
    drive(2'b01, 32'h000000F0, 32'd2, 5'd5);
    @(posedge clk); #1;
    @(negedge clk);
    drive(2'b00, 32'h0000000F, 32'd4, 5'd6);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    idle_in();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("flush_quiet%0d", k), {31'b0, out_valid}, 32'd0);
    end

    // Asynchronous reset mid-stream, between edges.
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'b00, 32'h00000003, 32'd8, 5'd10);
    @(posedge clk); #1;
    @(negedge clk);
    drive(2'b00, 32'h00000003, 32'd9, 5'd11);
    @(posedge clk); #1;
    @(negedge clk);
    idle_in();
    chk("arst_pre_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid",   {31'b0, out_valid},   32'd0);
    chk("arst_out_result",  out_result,           32'd0);
    chk("arst_out_rd",      {27'b0, out_rd},      32'd0);
    chk("arst_out_illegal", {31'b0, out_illegal}, 32'd0);
    chk("arst_in_ready",    {31'b0, in_ready},    32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    run_vec(7);
    chk("arst_after_drained", {31'b0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
